pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC register.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_load_use_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } pipe_state_t;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_MEM,
    HZ_BRANCH,
    HZ_LOAD_USE
  } hazard_cause_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A mispredict squashes the younger instructions, so any load-use
  // hazard they carry no longer matters.
  function automatic hazard_cause_t resolve_cause(input logic mispredict,
                                                  input logic load_use);
    if (mispredict) return HZ_BRANCH;
    if (load_use)   return HZ_LOAD_USE;
    return HZ_NONE;
  endfunction

  // Event counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_load_use_detect.sv
// Load-use hazard compare between the load in EX and the operands read in ID.
module pipe_load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic [4:0] rd_addr_i,
  input  logic       rd_wren_i,
  input  logic       is_load_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    rs1_hit    = rs1_used_i && (rs1_addr_i == rd_addr_i);
    rs2_hit    = rs2_used_i && (rs2_addr_i == rd_addr_i);
    load_use_o = is_load_i && rd_wren_i && (rd_addr_i != REG_X0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the PC and the IF_ID/ID_EX/EX_MEM/MEM_WB registers.
// Optional feature macro: PIPE_HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_ex_rd_wren,
  input  logic        i_ex_is_load,
  input  logic        i_ex_mispredict,
  input  logic        i_mem_req,
  input  logic        i_mem_ack,
  output logic        o_pc_stall,
  output logic        o_if_id_stall,
  output logic        o_if_id_flush,
  output logic        o_id_ex_stall,
  output logic        o_id_ex_flush,
  output logic        o_ex_mem_stall,
  output logic        o_mem_wb_flush,
  output logic        o_mem_err,
  output logic        o_state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_events
`endif
);

  // A zero timeout disables the forced exit; the counter then just sticks at all-ones.
  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = (MEM_TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(MEM_TIMEOUT);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  hazard_cause_t    cause;
  logic             timed_out;
  logic             mem_err;
  logic             load_use;

  pipe_load_use_detect u_load_use (
    .rs1_addr_i (i_id_rs1_addr),
    .rs2_addr_i (i_id_rs2_addr),
    .rs1_used_i (i_id_rs1_used),
    .rs2_used_i (i_id_rs2_used),
    .rd_addr_i  (i_ex_rd_addr),
    .rd_wren_i  (i_ex_rd_wren),
    .is_load_i  (i_ex_is_load),
    .load_use_o (load_use)
  );

  // State and wait counter; reset drops any pending memory access.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and selection of the single hazard being serviced this cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause     = HZ_NONE;
    timed_out = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_mem_req && !i_mem_ack) begin
          cause   = HZ_MEM;
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cause = resolve_cause(i_ex_mispredict, load_use);
        end
      end
      ST_MEM_WAIT: begin
        timed_out = (MEM_TIMEOUT != 0) && (cnt_q == CNT_MAX);
        if (i_mem_ack || timed_out) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          mem_err = !i_mem_ack;
          cause   = resolve_cause(i_ex_mispredict, load_use);
        end else begin
          cause = HZ_MEM;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Decode the serviced hazard into per-register controls, all held low during reset.
  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_mem_wb_flush = 1'b0;
    o_mem_err      = 1'b0;
    if (i_reset) begin
      o_mem_err = mem_err;
      case (cause)
        HZ_MEM: begin
          o_pc_stall     = 1'b1;
          o_if_id_stall  = 1'b1;
          o_id_ex_stall  = 1'b1;
          o_ex_mem_stall = 1'b1;
          o_mem_wb_flush = 1'b1;
        end
        HZ_BRANCH: begin
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
        end
        HZ_LOAD_USE: begin
          o_pc_stall    = 1'b1;
          o_if_id_stall = 1'b1;
          o_id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_state = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  // Saturating counts of stalled cycles and ID_EX flush cycles.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (o_pc_stall)    stall_cycles_q <= sat_inc32(stall_cycles_q);
      if (o_id_ex_flush) flush_events_q <= sat_inc32(flush_events_q);
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_events = flush_events_q;
`endif

endmodule
